// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, types and helpers for the 4-digit 7-segment display path.
package seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 4;
  localparam int CNT_W      = 16;

  // Digit enables are active-low: all ones means every digit is dark.
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = 4'b1111;

  typedef logic [BCD_W-1:0] bcd_t;

  // Codes 10..15 have no decimal glyph, so such a digit is shown dark.
  function automatic logic bcd_invalid(input bcd_t code);
    return code > 4'd9;
  endfunction

endpackage

// File: rtl/seg_scan_mux_scan_timer.sv
// scan_timer: slot counter / slot index generator for the multiplexed display.
// Exposes the values that will be loaded at the next edge so the display
// registers can follow the scan position with no extra latency.
module scan_timer
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] o_cnt_next,
  output logic [1:0]       o_slot_next,
  output logic             o_frame_end,
  output logic             o_frame_end_next
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [1:0]       SLOT_LAST = 2'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_slot;
  logic             w_cnt_wrap;

  // Next scan position: cnt wraps after the last cycle of a slot, slot then advances 3 -> 0
  always_comb begin
    w_cnt_wrap       = (r_cnt == CNT_LAST);
    o_cnt_next       = w_cnt_wrap ? '0 : r_cnt + 1'b1;
    o_slot_next      = w_cnt_wrap ? r_slot + 1'b1 : r_slot;
    o_frame_end      = w_cnt_wrap && (r_slot == SLOT_LAST);
    o_frame_end_next = (o_cnt_next == CNT_LAST) && (o_slot_next == SLOT_LAST);
  end

  // Scan position registers; reset parks the scan at slot 0, cnt 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_slot <= '0;
    end else begin
      r_cnt  <= o_cnt_next;
      r_slot <= o_slot_next;
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: 4-digit multiplexed 7-segment scan driver with per-slot blanking
// window, invalid-code and leading-zero blanking, decimal points, and
// frame-synchronous (tear-free) update of the displayed value.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_en,
  input  logic        lzb_en,
  input  logic        upd,
  output logic        upd_ack,
  output logic [3:0]  bcd,
  output logic        dp_n,
  output logic [3:0]  dig_n
);

  localparam logic [CNT_W-1:0] BLANK_L = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] w_cnt_next;
  logic [1:0]       w_slot_next;
  logic             w_frame_end;
  logic             w_frame_end_next;

  // Pending (requested) and shadow (displayed) copies of the display value
  logic [15:0] r_pend_digits, r_sh_digits;
  logic [3:0]  r_pend_dp,     r_sh_dp;
  logic        r_pend_lzb,    r_sh_lzb;
  logic        r_pending;

  logic        r_upd_ack;
  logic [3:0]  r_bcd;
  logic        r_dp_n;
  logic [3:0]  r_dig_n;

  logic        w_commit;
  logic        w_pending_next;
  logic [15:0] w_sh_digits_next;
  logic [3:0]  w_sh_dp_next;
  logic        w_sh_lzb_next;

  logic [BCD_W-1:0]      w_code [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_zero;
  logic [NUM_DIGITS-1:0] w_lz;
  logic [NUM_DIGITS-1:0] w_visible;

  logic [3:0]  w_bcd_next;
  logic [3:0]  w_dig_n_next;
  logic        w_dp_n_next;

  scan_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_timer (
    .clk              (clk),
    .rst_n            (rst_n),
    .o_cnt_next       (w_cnt_next),
    .o_slot_next      (w_slot_next),
    .o_frame_end      (w_frame_end),
    .o_frame_end_next (w_frame_end_next)
  );

  // Commit the older pending value at the frame boundary; an upd in the same
  // cycle lands in pending and waits for the next boundary.
  always_comb begin
    w_commit         = w_frame_end & r_pending;
    w_pending_next   = upd | (r_pending & ~w_frame_end);
    w_sh_digits_next = w_commit ? r_pend_digits : r_sh_digits;
    w_sh_dp_next     = w_commit ? r_pend_dp     : r_sh_dp;
    w_sh_lzb_next    = w_commit ? r_pend_lzb    : r_sh_lzb;
  end

  // Per-digit code extraction and invalid / leading-zero visibility
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_code[gi]    = w_sh_digits_next[gi*BCD_W +: BCD_W];
      assign w_zero[gi]    = (w_code[gi] == '0);
      assign w_visible[gi] = ~(bcd_invalid(w_code[gi]) | w_lz[gi]);
    end
  endgenerate

  // Leading-zero chain from the top digit down; digit 0 always stays lit
  always_comb begin
    w_lz = '0;
    w_lz[NUM_DIGITS-1] = w_sh_lzb_next & w_zero[NUM_DIGITS-1];
    for (int k = NUM_DIGITS - 2; k >= 1; k--) begin
      w_lz[k] = w_lz[k+1] & w_zero[k];
    end
  end

  // Display values for the scan position being loaded at this edge
  always_comb begin
    w_dig_n_next = DIG_OFF;
    if ((w_cnt_next >= BLANK_L) && w_visible[w_slot_next]) begin
      w_dig_n_next[w_slot_next] = 1'b0;
    end
    w_dp_n_next = ~(~w_dig_n_next[w_slot_next] & w_sh_dp_next[w_slot_next]);
    w_bcd_next  = w_code[w_slot_next];
  end

  // Pending capture, shadow commit and registered display outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend_digits <= '0;
      r_pend_dp     <= '0;
      r_pend_lzb    <= 1'b0;
      r_pending     <= 1'b0;
      r_sh_digits   <= '0;
      r_sh_dp       <= '0;
      r_sh_lzb      <= 1'b0;
      r_upd_ack     <= 1'b0;
      r_bcd         <= '0;
      r_dp_n        <= 1'b1;
      r_dig_n       <= DIG_OFF;
    end else begin
      if (upd) begin
        r_pend_digits <= digits;
        r_pend_dp     <= dp_en;
        r_pend_lzb    <= lzb_en;
      end
      r_pending   <= w_pending_next;
      r_sh_digits <= w_sh_digits_next;
      r_sh_dp     <= w_sh_dp_next;
      r_sh_lzb    <= w_sh_lzb_next;
      // Ack is high during the boundary cycle whose closing edge commits
      r_upd_ack   <= w_frame_end_next & w_pending_next;
      r_bcd       <= w_bcd_next;
      r_dp_n      <= w_dp_n_next;
      r_dig_n     <= w_dig_n_next;
    end
  end

  assign upd_ack = r_upd_ack;
  assign bcd     = r_bcd;
  assign dp_n    = r_dp_n;
  assign dig_n   = r_dig_n;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: scoreboard bench for seg_scan_mux with SCAN_DIV = 8, BLANK_CYC = 2.
module tb_seg_scan_mux;

  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  dp;
    logic        lzb;
  } img_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits;
  logic [3:0]  dp_en;
  logic        lzb_en;
  logic        upd;
  logic        upd_ack;
  logic [3:0]  bcd;
  logic        dp_n;
  logic [3:0]  dig_n;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_acks = 0;
  int   last_ack_frame = -1;
  int   f_sent = 0;
  int   b_cnt = 0;
  int   b_slot = 0;
  int   b_frame = 0;
  img_t sb_q[$];
  img_t m_sh = '0;

  always #5 clk = ~clk;

  seg_scan_mux #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .digits  (digits),
    .dp_en   (dp_en),
    .lzb_en  (lzb_en),
    .upd     (upd),
    .upd_ack (upd_ack),
    .bcd     (bcd),
    .dp_n    (dp_n),
    .dig_n   (dig_n)
  );

  // Reference scan position (slot / cnt / frame number)
  always @(posedge clk) begin
    if (!rst_n) begin
      b_cnt <= 0; b_slot <= 0; b_frame <= 0;
    end else if (b_cnt == SCAN_DIV - 1) begin
      b_cnt <= 0;
      if (b_slot == 3) begin
        b_slot <= 0; b_frame <= b_frame + 1;
      end else begin
        b_slot <= b_slot + 1;
      end
    end else begin
      b_cnt <= b_cnt + 1;
    end
  end

  // Expected {bcd, dig_n, dp_n} for a displayed image at a scan position
  function automatic logic [8:0] exp_out(input img_t im, input int s, input int c);
    logic [3:0] code;
    logic       show;
    logic [3:0] dn;
    logic       dpn;
    code = im.d[s*4 +: 4];
    show = (code < 4'd10) && !(im.lzb && (s != 0) && ((im.d >> (4*s)) == 16'h0));
    dn = 4'b1111;
    if (show && (c >= BLANK_CYC)) dn[s] = 1'b0;
    dpn = !((dn[s] == 1'b0) && im.dp[s]);
    return {code, dn, dpn};
  endfunction

  // Advance one cycle; an ack seen mid-cycle pops the scoreboard into the display model
  task automatic tick();
    @(negedge clk);
    if (upd_ack === 1'b1) begin
      n_checks++;
      if (sb_q.size() == 0 || b_slot != 3 || b_cnt != SCAN_DIV - 1) begin
        n_errors++;
        $display("FAIL upd_ack_commit: ack at frame %0d slot %0d cnt %0d with %0d queued, required slot 3 cnt %0d with a queued update",
                 b_frame, b_slot, b_cnt, sb_q.size(), SCAN_DIV - 1);
      end
      if (sb_q.size() != 0) m_sh = sb_q.pop_front();
      n_acks++;
      last_ack_frame = b_frame;
      $display("ack   frame %0d: shadow digits=%h dp=%b lzb=%b", b_frame, m_sh.d, m_sh.dp, m_sh.lzb);
    end
    @(posedge clk);
    #1;
  endtask

  // One-cycle upd request; inputs are scrambled afterwards since they must be ignored
  task automatic send_upd(input logic [15:0] d, input logic [3:0] dp, input logic l);
    img_t im;
    im = '{d: d, dp: dp, lzb: l};
    digits = d; dp_en = dp; lzb_en = l; upd = 1'b1;
    sb_q.push_back(im);
    f_sent = b_frame;
    $display("upd   frame %0d slot %0d cnt %0d: digits=%h dp=%b lzb=%b", b_frame, b_slot, b_cnt, d, dp, l);
    tick();
    upd = 1'b0;
    digits = 16'($urandom); dp_en = 4'($urandom); lzb_en = 1'($urandom);
  endtask

  task automatic test_reset();
    logic [8:0] e;
    int acks0;
    rst_n = 1'b0; upd = 1'b1; digits = 16'h9999; dp_en = 4'hF; lzb_en = 1'b1;
    repeat (3) begin
      tick();
      n_checks++;
      if ({upd_ack, bcd, dig_n, dp_n} !== {1'b0, 4'h0, 4'b1111, 1'b1}) begin
        n_errors++;
        $display("FAIL reset_hold: got ack=%b bcd=%h dig_n=%b dp_n=%b, expected 0 0 1111 1", upd_ack, bcd, dig_n, dp_n);
      end
    end
    upd = 1'b0; rst_n = 1'b1;
    sb_q.delete(); m_sh = '0; acks0 = n_acks;
    do begin
      e = exp_out(m_sh, b_slot, b_cnt);
      n_checks++;
      if ({bcd, dig_n, dp_n} !== e) begin
        n_errors++;
        $display("FAIL reset_frame0 s%0d c%0d: got bcd=%h dig_n=%b dp_n=%b, expected bcd=%h dig_n=%b dp_n=%b", b_slot, b_cnt, bcd, dig_n, dp_n, e[8:5], e[4:1], e[0]);
      end
      tick();
    end while (!(b_slot == 0 && b_cnt == 0));
    n_checks++;
    if (n_acks != acks0) begin
      n_errors++;
      $display("FAIL reset_upd_ignored: got %0d acks, expected 0", n_acks - acks0);
    end
  endtask

  task automatic test_scan();
    logic [8:0] e;
    int acks0;
    acks0 = n_acks;
    send_upd(16'h1234, 4'h0, 1'b0);
    do begin
      e = exp_out(m_sh, b_slot, b_cnt);
      n_checks++;
      if ({bcd, dig_n, dp_n} !== e) begin
        n_errors++;
        $display("FAIL scan_wait s%0d c%0d: got bcd=%h dig_n=%b dp_n=%b, expected bcd=%h dig_n=%b dp_n=%b", b_slot, b_cnt, bcd, dig_n, dp_n, e[8:5], e[4:1], e[0]);
      end
      tick();
    end while (!(b_slot == 0 && b_cnt == 0));
    n_checks++;
    if (n_acks != acks0 + 1 || last_ack_frame != f_sent) begin
      n_errors++;
      $display("FAIL scan_ack: got %0d acks last in frame %0d, expected 1 ack in frame %0d", n_acks - acks0, last_ack_frame, f_sent);
    end
    do begin
      e = exp_out(m_sh, b_slot, b_cnt);
      n_checks++;
      if ({bcd, dig_n, dp_n} !== e) begin
        n_errors++;
        $display("FAIL scan_1234 s%0d c%0d: got bcd=%h dig_n=%b dp_n=%b, expected bcd=%h dig_n=%b dp_n=%b", b_slot, b_cnt, bcd, dig_n, dp_n, e[8:5], e[4:1], e[0]);
      end
      tick();
    end while (!(b_slot == 0 && b_cnt == 0));
  endtask

  task automatic test_lzb_dp();
    logic [8:0] e;
    logic [15:0] d_tab [3];
    logic [3:0]  dp_tab [3];
    int acks0;
    d_tab  = '{16'h0005, 16'h0000, 16'h0305};
    dp_tab = '{4'b0000, 4'b0000, 4'b0010};
    for (int t = 0; t < 3; t++) begin
      acks0 = n_acks;
      send_upd(d_tab[t], dp_tab[t], 1'b1);
      do begin
        e = exp_out(m_sh, b_slot, b_cnt);
        n_checks++;
        if ({bcd, dig_n, dp_n} !== e) begin
          n_errors++;
          $display("FAIL lzb_wait%0d s%0d c%0d: got bcd=%h dig_n=%b dp_n=%b, expected bcd=%h dig_n=%b dp_n=%b", t, b_slot, b_cnt, bcd, dig_n, dp_n, e[8:5], e[4:1], e[0]);
        end
        tick();
      end while (!(b_slot == 0 && b_cnt == 0));
      n_checks++;
      if (n_acks != acks0 + 1 || last_ack_frame != f_sent) begin
        n_errors++;
        $display("FAIL lzb_ack%0d: got %0d acks last in frame %0d, expected 1 ack in frame %0d", t, n_acks - acks0, last_ack_frame, f_sent);
      end
      do begin
        e = exp_out(m_sh, b_slot, b_cnt);
        n_checks++;
        if ({bcd, dig_n, dp_n} !== e) begin
          n_errors++;
          $display("FAIL lzb_show_%h s%0d c%0d: got bcd=%h dig_n=%b dp_n=%b, expected bcd=%h dig_n=%b dp_n=%b", d_tab[t], b_slot, b_cnt, bcd, dig_n, dp_n, e[8:5], e[4:1], e[0]);
        end
        tick();
      end while (!(b_slot == 0 && b_cnt == 0));
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] e;
    img_t dummy;
    int acks0;
    // two requests in one frame: the later one wins, single ack
    acks0 = n_acks;
    send_upd(16'h1111, 4'h1, 1'b0);
    tick(); tick();
    dummy = sb_q.pop_back();
    send_upd(16'h2222, 4'h4, 1'b0);
    do begin
      e = exp_out(m_sh, b_slot, b_cnt);
      n_checks++;
      if ({bcd, dig_n, dp_n} !== e) begin
        n_errors++;
        $display("FAIL b2b_wait s%0d c%0d: got bcd=%h dig_n=%b dp_n=%b, expected bcd=%h dig_n=%b dp_n=%b", b_slot, b_cnt, bcd, dig_n, dp_n, e[8:5], e[4:1], e[0]);
      end
      tick();
    end while (!(b_slot == 0 && b_cnt == 0));
    n_checks++;
    if (n_acks != acks0 + 1 || last_ack_frame != f_sent || m_sh.d != 16'h2222) begin
      n_errors++;
      $display("FAIL b2b_overwrite: got %0d acks shadow %h, expected 1 ack shadow 2222 (dropped %h)", n_acks - acks0, m_sh.d, dummy.d);
    end
    // request on the boundary cycle with nothing pending: ack one frame later
    while (!(b_slot == 3 && b_cnt == SCAN_DIV - 1)) begin
      e = exp_out(m_sh, b_slot, b_cnt);
      n_checks++;
      if ({bcd, dig_n, dp_n} !== e) begin
        n_errors++;
        $display("FAIL b2b_2222 s%0d c%0d: got bcd=%h dig_n=%b dp_n=%b, expected bcd=%h dig_n=%b dp_n=%b", b_slot, b_cnt, bcd, dig_n, dp_n, e[8:5], e[4:1], e[0]);
      end
      tick();
    end
    acks0 = n_acks;
    send_upd(16'h0987, 4'h8, 1'b1);
    do begin
      e = exp_out(m_sh, b_slot, b_cnt);
      n_checks++;
      if ({bcd, dig_n, dp_n} !== e) begin
        n_errors++;
        $display("FAIL b2b_boundary s%0d c%0d: got bcd=%h dig_n=%b dp_n=%b, expected bcd=%h dig_n=%b dp_n=%b", b_slot, b_cnt, bcd, dig_n, dp_n, e[8:5], e[4:1], e[0]);
      end
      tick();
    end while (!(b_slot == 0 && b_cnt == 0));
    n_checks++;
    if (n_acks != acks0 + 1 || last_ack_frame != f_sent + 1) begin
      n_errors++;
      $display("FAIL b2b_boundary_ack: got %0d acks last in frame %0d, expected 1 ack in frame %0d", n_acks - acks0, last_ack_frame, f_sent + 1);
    end
    // request on the boundary cycle with one pending: older commits now, newer next frame
    acks0 = n_acks;
    send_upd(16'h5678, 4'h0, 1'b0);
    while (!(b_slot == 3 && b_cnt == SCAN_DIV - 1)) begin
      e = exp_out(m_sh, b_slot, b_cnt);
      n_checks++;
      if ({bcd, dig_n, dp_n} !== e) begin
        n_errors++;
        $display("FAIL b2b_0987 s%0d c%0d: got bcd=%h dig_n=%b dp_n=%b, expected bcd=%h dig_n=%b dp_n=%b", b_slot, b_cnt, bcd, dig_n, dp_n, e[8:5], e[4:1], e[0]);
      end
      tick();
    end
    send_upd(16'h0042, 4'h1, 1'b1);
    n_checks++;
    if (n_acks != acks0 + 1 || last_ack_frame != f_sent || m_sh.d != 16'h5678) begin
      n_errors++;
      $display("FAIL b2b_collide_old: got %0d acks shadow %h, expected 1 ack shadow 5678 in frame %0d", n_acks - acks0, m_sh.d, f_sent);
    end
    do begin
      e = exp_out(m_sh, b_slot, b_cnt);
      n_checks++;
      if ({bcd, dig_n, dp_n} !== e) begin
        n_errors++;
        $display("FAIL b2b_5678 s%0d c%0d: got bcd=%h dig_n=%b dp_n=%b, expected bcd=%h dig_n=%b dp_n=%b", b_slot, b_cnt, bcd, dig_n, dp_n, e[8:5], e[4:1], e[0]);
      end
      tick();
    end while (!(b_slot == 0 && b_cnt == 0));
    n_checks++;
    if (n_acks != acks0 + 2 || last_ack_frame != f_sent + 1 || m_sh.d != 16'h0042) begin
      n_errors++;
      $display("FAIL b2b_collide_new: got %0d acks shadow %h, expected 2 acks shadow 0042", n_acks - acks0, m_sh.d);
    end
    do begin
      e = exp_out(m_sh, b_slot, b_cnt);
      n_checks++;
      if ({bcd, dig_n, dp_n} !== e) begin
        n_errors++;
        $display("FAIL b2b_0042 s%0d c%0d: got bcd=%h dig_n=%b dp_n=%b, expected bcd=%h dig_n=%b dp_n=%b", b_slot, b_cnt, bcd, dig_n, dp_n, e[8:5], e[4:1], e[0]);
      end
      tick();
    end while (!(b_slot == 0 && b_cnt == 0));
  endtask

  task automatic test_invalid_reset();
    logic [8:0] e;
    int acks0;
    acks0 = n_acks;
    send_upd(16'h56C8, 4'b0010, 1'b0);
    do begin
      e = exp_out(m_sh, b_slot, b_cnt);
      n_checks++;
      if ({bcd, dig_n, dp_n} !== e) begin
        n_errors++;
        $display("FAIL inv_wait s%0d c%0d: got bcd=%h dig_n=%b dp_n=%b, expected bcd=%h dig_n=%b dp_n=%b", b_slot, b_cnt, bcd, dig_n, dp_n, e[8:5], e[4:1], e[0]);
      end
      tick();
    end while (!(b_slot == 0 && b_cnt == 0));
    n_checks++;
    if (n_acks != acks0 + 1 || last_ack_frame != f_sent) begin
      n_errors++;
      $display("FAIL inv_ack: got %0d acks last in frame %0d, expected 1 ack in frame %0d", n_acks - acks0, last_ack_frame, f_sent);
    end
    while (!(b_slot == 2 && b_cnt == 3)) begin
      e = exp_out(m_sh, b_slot, b_cnt);
      n_checks++;
      if ({bcd, dig_n, dp_n} !== e) begin
        n_errors++;
        $display("FAIL inv_56c8 s%0d c%0d: got bcd=%h dig_n=%b dp_n=%b, expected bcd=%h dig_n=%b dp_n=%b", b_slot, b_cnt, bcd, dig_n, dp_n, e[8:5], e[4:1], e[0]);
      end
      tick();
    end
    send_upd(16'h7777, 4'h0, 1'b0);
    tick();
    // now at slot 2 cnt 5 with an update pending: reset discards it
    rst_n = 1'b0; upd = 1'b1; digits = 16'h8888;
    sb_q.delete(); m_sh = '0; acks0 = n_acks;
    repeat (3) begin
      tick();
      n_checks++;
      if ({upd_ack, bcd, dig_n, dp_n} !== {1'b0, 4'h0, 4'b1111, 1'b1}) begin
        n_errors++;
        $display("FAIL inv_reset_hold: got ack=%b bcd=%h dig_n=%b dp_n=%b, expected 0 0 1111 1", upd_ack, bcd, dig_n, dp_n);
      end
    end
    rst_n = 1'b1; upd = 1'b0;
    do begin
      e = exp_out(m_sh, b_slot, b_cnt);
      n_checks++;
      if ({bcd, dig_n, dp_n} !== e) begin
        n_errors++;
        $display("FAIL inv_restart s%0d c%0d: got bcd=%h dig_n=%b dp_n=%b, expected bcd=%h dig_n=%b dp_n=%b", b_slot, b_cnt, bcd, dig_n, dp_n, e[8:5], e[4:1], e[0]);
      end
      tick();
    end while (!(b_slot == 0 && b_cnt == 0));
    n_checks++;
    if (n_acks != acks0) begin
      n_errors++;
      $display("FAIL inv_pending_discarded: got %0d acks after reset, expected 0", n_acks - acks0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected the bench to finish first");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; upd = 1'b0; digits = 16'h0; dp_en = 4'h0; lzb_en = 1'b0;
    test_reset();
    test_scan();
    test_lzb_dp();
    test_back_to_back();
    test_invalid_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
